// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main controller: opcodes, states,
// datapath select codes, trap causes and the per-state control word.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_DECODE    = 5'd1,
        S_EXEC_R    = 5'd2,
        S_EXEC_I    = 5'd3,
        S_LUI       = 5'd4,
        S_AUIPC     = 5'd5,
        S_MEM_ADDR  = 5'd6,
        S_MEM_READ  = 5'd7,
        S_MEM_WB    = 5'd8,
        S_MEM_WRITE = 5'd9,
        S_ALU_WB    = 5'd10,
        S_BRANCH    = 5'd11,
        S_JAL       = 5'd12,
        S_JALR      = 5'd13,
        S_JALR_LINK = 5'd14,
        S_TRAP      = 5'd15
    } state_t;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_MEM    = 2'b01;
    localparam logic [1:0] RS_ALU    = 2'b10;

    localparam logic [1:0] A_PC      = 2'b00;
    localparam logic [1:0] A_OLDPC   = 2'b01;
    localparam logic [1:0] A_RS1     = 2'b10;
    localparam logic [1:0] A_ZERO    = 2'b11;

    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_IMM     = 2'b01;
    localparam logic [1:0] B_FOUR    = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // fetch_wr and br are qualifiers resolved in the current cycle (mem_ready, branch flags)
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       fetch_wr;
        logic       pc_write;
        logic       br;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch_wr   = 1'b1;
                c.result_src = RS_ALU;
                c.alu_src_b  = B_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_IMM;
            end
            S_EXEC_R: begin
                c.alu_src_a = A_RS1;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = A_RS1;
                c.alu_src_b = B_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                c.alu_src_a = A_ZERO;
                c.alu_src_b = B_IMM;
            end
            S_AUIPC: begin
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_IMM;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = A_RS1;
                c.alu_src_b = B_IMM;
            end
            S_MEM_READ: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                c.result_src = RS_MEM;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_ALU_WB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.br        = 1'b1;
                c.alu_src_a = A_RS1;
                c.alu_op    = ALU_CMP;
            end
            S_JAL: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_FOUR;
            end
            S_JALR: begin
                c.pc_write   = 1'b1;
                c.result_src = RS_ALU;
                c.alu_src_a  = A_RS1;
                c.alu_src_b  = B_IMM;
            end
            S_JALR_LINK: begin
                c.alu_src_a = A_OLDPC;
                c.alu_src_b = B_FOUR;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, selects and enables out.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;

    modport master (
        input  opcode, funct3, funct7, zero, lt, ltu, mem_ready,
        output mem_req, pc_write, adr_src, mem_write, ir_write,
               result_src, alu_src_a, alu_src_b, reg_write, alu_op
    );

    modport slave (
        output opcode, funct3, funct7, zero, lt, ltu, mem_ready,
        input  mem_req, pc_write, adr_src, mem_write, ir_write,
               result_src, alu_src_a, alu_src_b, reg_write, alu_op
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of the current memory access and flags the last allowed one.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_active && !i_ready) begin
            r_count <= r_count + CW'(1);
        end
    end

    // A ready in the terminal cycle is a normal completion, so it masks expiry
    assign o_expired = (TIMEOUT_CYCLES > 0) && i_active && !i_ready && (r_count == TC);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequencing, memory handshake
// with timeout, sticky illegal/timeout trap and retired-instruction counter.
import ctrl_pkg::*;

// state     | meaning
// FETCH     | read instruction, PC+4 ; DECODE | ALUOut = branch/JAL target
// EXEC_R/I  | ALU op on rs1 and rs2/imm ; LUI/AUIPC | imm or oldPC+imm
// MEM_ADDR  | rs1+imm ; MEM_READ/MEM_WRITE | data access ; MEM_WB | load writeback
// ALU_WB    | ALUOut writeback ; BRANCH | compare, conditional PC write
// JAL/JALR  | PC write ; JALR_LINK | oldPC+4 link ; TRAP | sticky halt until rst
module multicycle_ctrl_fsm #(
    parameter int MEM_HANDSHAKE  = 1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_fsm_if.master bus,
    output logic                 o_trap,
    output logic [1:0]           o_trap_cause,
    output logic [RETIRE_W-1:0]  o_retired,
    output logic [4:0]           o_state_dbg
);
    state_t              r_state;
    ctl_t                r_ctl;
    logic                r_trap;
    logic [1:0]          r_trap_cause;
    logic [RETIRE_W-1:0] r_retired;

    state_t     w_next;
    logic [1:0] w_cause;
    logic       w_retire;
    logic       w_illegal;
    logic       w_rdy;
    logic       w_taken;
    logic       w_expired;
    logic       w_tmr_clr;
    logic       w_tmr_active;
    logic       w_run;

    assign w_rdy        = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign w_tmr_active = is_mem_state(r_state);
    assign w_tmr_clr    = is_mem_state(w_next) && (w_next != r_state);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_active (w_tmr_active),
        .i_ready  (w_rdy),
        .o_expired(w_expired)
    );

    always_comb begin
        w_taken = 1'b0;
        unique case (bus.funct3)
            3'b000:  w_taken = bus.zero;
            3'b001:  w_taken = !bus.zero;
            3'b100:  w_taken = bus.lt;
            3'b101:  w_taken = !bus.lt;
            3'b110:  w_taken = bus.ltu;
            3'b111:  w_taken = !bus.ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_cause   = CAUSE_NONE;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (w_rdy) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                unique case (bus.opcode)
                    OPC_R: begin
                        if (bus.funct7 == 7'h00 || bus.funct7 == 7'h20) w_next = S_EXEC_R;
                        else w_illegal = 1'b1;
                    end
                    OPC_IMM:              w_next = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:  w_next = S_MEM_ADDR;
                    OPC_BRANCH: begin
                        if (bus.funct3 == 3'b010 || bus.funct3 == 3'b011) w_illegal = 1'b1;
                        else w_next = S_BRANCH;
                    end
                    OPC_JAL:   w_next = S_JAL;
                    OPC_JALR:  w_next = S_JALR;
                    OPC_LUI:   w_next = S_LUI;
                    OPC_AUIPC: w_next = S_AUIPC;
                    default:   w_illegal = 1'b1;
                endcase
                if (w_illegal) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_ILLEGAL;
                end
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL, S_JALR_LINK: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = (bus.opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (w_rdy) begin
                    w_next = S_MEM_WB;
                end else if (w_expired) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WRITE: begin
                if (w_rdy) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_expired) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_JALR:  w_next = S_JALR_LINK;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Control word is registered for the state being entered, so outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_ctl        <= ctl_for(S_FETCH);
            r_trap       <= 1'b0;
            r_trap_cause <= CAUSE_NONE;
            r_retired    <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_for(w_next);
            if (w_retire) begin
                r_retired <= r_retired + RETIRE_W'(1);
            end
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_cause;
            end
        end
    end

    assign w_run = !rst;

    always_comb begin
        bus.mem_req    = w_run & r_ctl.mem_req;
        bus.adr_src    = w_run & r_ctl.adr_src;
        bus.mem_write  = w_run & r_ctl.mem_write;
        bus.ir_write   = w_run & r_ctl.fetch_wr & w_rdy;
        bus.pc_write   = w_run & (r_ctl.pc_write | (r_ctl.fetch_wr & w_rdy) | (r_ctl.br & w_taken));
        bus.reg_write  = w_run & r_ctl.reg_write;
        bus.result_src = w_run ? r_ctl.result_src : 2'b00;
        bus.alu_src_a  = w_run ? r_ctl.alu_src_a : 2'b00;
        bus.alu_src_b  = w_run ? r_ctl.alu_src_b : 2'b00;
        bus.alu_op     = w_run ? r_ctl.alu_op : 2'b00;
    end

    assign o_trap       = w_run & r_trap;
    assign o_trap_cause = w_run ? r_trap_cause : CAUSE_NONE;
    assign o_retired    = r_retired;
    assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle stimulus and expected outputs
// are queued per scenario, then applied and compared cycle by cycle.
module tb_multicycle_ctrl_fsm;

    localparam logic [4:0] ST_FETCH = 5'd0, ST_DECODE = 5'd1, ST_EXEC_R = 5'd2, ST_EXEC_I = 5'd3;
    localparam logic [4:0] ST_LUI = 5'd4, ST_AUIPC = 5'd5, ST_MEM_ADDR = 5'd6, ST_MEM_READ = 5'd7;
    localparam logic [4:0] ST_MEM_WB = 5'd8, ST_MEM_WRITE = 5'd9, ST_ALU_WB = 5'd10, ST_BRANCH = 5'd11;
    localparam logic [4:0] ST_JAL = 5'd12, ST_JALR = 5'd13, ST_JALR_LINK = 5'd14, ST_TRAP = 5'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;
    logic [4:0]  state_dbg;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(
        .MEM_HANDSHAKE (1),
        .TIMEOUT_CYCLES(16),
        .RETIRE_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_trap      (trap),
        .o_trap_cause(trap_cause),
        .o_retired   (retired),
        .o_state_dbg (state_dbg)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        zero;
        logic        lt;
        logic        ltu;
        logic        rdy;
        logic [21:0] ev;
        logic [31:0] er;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 0;
    logic [6:0]  cur_op = 7'd0;
    logic [2:0]  cur_f3 = 3'd0;
    logic [6:0]  cur_f7 = 7'd0;
    logic        cur_zero = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0;

    // expected {state, req, adr, mw, irw, pcw, rw, rs, a, b, op, trap, cause}
    function automatic logic [21:0] exp_vec(input logic [4:0] s, input logic rdy,
                                            input logic tk, input logic [1:0] c);
        logic req, adr, mw, irw, pcw, rw, tr;
        logic [1:0] rs, a, b, op, cz;
        {req, adr, mw, irw, pcw, rw, tr} = '0;
        rs = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00; cz = 2'b00;
        case (s)
            ST_FETCH:     begin req = 1; irw = rdy; pcw = rdy; rs = 2'b10; b = 2'b10; end
            ST_DECODE:    begin a = 2'b01; b = 2'b01; end
            ST_EXEC_R:    begin a = 2'b10; op = 2'b10; end
            ST_EXEC_I:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
            ST_LUI:       begin a = 2'b11; b = 2'b01; end
            ST_AUIPC:     begin a = 2'b01; b = 2'b01; end
            ST_MEM_ADDR:  begin a = 2'b10; b = 2'b01; end
            ST_MEM_READ:  begin req = 1; adr = 1; end
            ST_MEM_WB:    begin rs = 2'b01; rw = 1; end
            ST_MEM_WRITE: begin req = 1; adr = 1; mw = 1; end
            ST_ALU_WB:    rw = 1;
            ST_BRANCH:    begin a = 2'b10; op = 2'b01; pcw = tk; end
            ST_JAL:       begin pcw = 1; a = 2'b01; b = 2'b10; end
            ST_JALR:      begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1; end
            ST_JALR_LINK: begin a = 2'b01; b = 2'b10; end
            ST_TRAP:      begin tr = 1; cz = c; end
            default:      ;
        endcase
        return {s, req, adr, mw, irw, pcw, rw, rs, a, b, op, tr, cz};
    endfunction

    function automatic logic [21:0] obs();
        return {state_dbg, bus.mem_req, bus.adr_src, bus.mem_write, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                trap, trap_cause};
    endfunction

    task automatic plan(input logic [4:0] s, input logic rdy, input logic tk,
                        input logic [1:0] c, input logic ret);
        ent_t e;
        e.op = cur_op; e.f3 = cur_f3; e.f7 = cur_f7;
        e.zero = cur_zero; e.lt = cur_lt; e.ltu = cur_ltu; e.rdy = rdy;
        e.ev = exp_vec(s, rdy, tk, c);
        e.er = exp_ret;
        sb.push_back(e);
        if (ret) exp_ret = exp_ret + 1;
    endtask

    task automatic drive(input ent_t e);
        bus.opcode = e.op; bus.funct3 = e.f3; bus.funct7 = e.f7;
        bus.zero = e.zero; bus.lt = e.lt; bus.ltu = e.ltu; bus.mem_ready = e.rdy;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
    endtask

    task automatic test_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs() !== 22'd0) begin
            errors++;
            $display("FAIL reset_%s outputs got %h exp %h", tag, obs(), 22'd0);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_%s retired got %0d exp 0", tag, retired);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    task automatic test_add();
        ent_t e;
        int cyc = 0;
        set_instr(7'b0110011, 3'b000, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0);
        plan(ST_EXEC_R, 1, 0, 0, 0); plan(ST_ALU_WB, 1, 0, 0, 1);
        plan(ST_FETCH, 1, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL add c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            checks++;
            if (retired !== e.er) begin errors++; $display("FAIL add c%0d retired got %0d exp %0d", cyc, retired, e.er); end
            @(posedge clk); #1; cyc++;
        end
        sb.delete();
        // discard the trailing FETCH: next scenario starts from it again
        exp_ret = 1;
        rst = 1'b0;
    endtask

    task automatic test_fetch_wait();
        ent_t e;
        int cyc = 0;
        set_instr(7'b0010011, 3'b000, 7'h00);
        for (int i = 0; i < 3; i++) plan(ST_FETCH, 0, 0, 0, 0);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0);
        plan(ST_EXEC_I, 1, 0, 0, 0); plan(ST_ALU_WB, 1, 0, 0, 1);
        for (int i = 0; i < 15; i++) plan(ST_FETCH, 0, 0, 0, 0);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0);
        plan(ST_EXEC_I, 1, 0, 0, 0); plan(ST_ALU_WB, 1, 0, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL fetch_wait c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            checks++;
            if (retired !== e.er) begin errors++; $display("FAIL fetch_wait c%0d retired got %0d exp %0d", cyc, retired, e.er); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_branch();
        ent_t e;
        int cyc = 0;
        logic [6:0] tab [7];
        logic [6:0] t;
        // {funct3, zero, lt, ltu, taken}
        tab = '{7'b100_0_1_0_1, 7'b100_0_0_0_0, 7'b000_1_0_0_1, 7'b001_1_0_0_0,
                7'b101_0_0_0_1, 7'b110_0_0_1_1, 7'b111_0_0_1_0};
        for (int i = 0; i < 7; i++) begin
            t = tab[i];
            set_instr(7'b1100011, t[6:4], 7'h00);
            cur_zero = t[3]; cur_lt = t[2]; cur_ltu = t[1];
            plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0);
            plan(ST_BRANCH, 1, t[0], 0, 1);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL branch c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            checks++;
            if (retired !== e.er) begin errors++; $display("FAIL branch c%0d retired got %0d exp %0d", cyc, retired, e.er); end
            @(posedge clk); #1; cyc++;
        end
        cur_zero = 0; cur_lt = 0; cur_ltu = 0;
    endtask

    task automatic test_jalr();
        ent_t e;
        int cyc = 0;
        set_instr(7'b1100111, 3'b000, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_JALR, 1, 0, 0, 0);
        plan(ST_JALR_LINK, 1, 0, 0, 0); plan(ST_ALU_WB, 1, 0, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL jalr c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            checks++;
            if (retired !== e.er) begin errors++; $display("FAIL jalr c%0d retired got %0d exp %0d", cyc, retired, e.er); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int cyc = 0;
        set_instr(7'b0000011, 3'b010, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_MEM_ADDR, 1, 0, 0, 0);
        plan(ST_MEM_READ, 0, 0, 0, 0); plan(ST_MEM_READ, 1, 0, 0, 0); plan(ST_MEM_WB, 1, 0, 0, 1);
        set_instr(7'b0100011, 3'b010, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_MEM_ADDR, 1, 0, 0, 0);
        plan(ST_MEM_WRITE, 0, 0, 0, 0); plan(ST_MEM_WRITE, 1, 0, 0, 1);
        set_instr(7'b1101111, 3'b000, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_JAL, 1, 0, 0, 0);
        plan(ST_ALU_WB, 1, 0, 0, 1);
        set_instr(7'b0110111, 3'b000, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_LUI, 1, 0, 0, 0);
        plan(ST_ALU_WB, 1, 0, 0, 1);
        set_instr(7'b0010111, 3'b000, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_AUIPC, 1, 0, 0, 0);
        plan(ST_ALU_WB, 1, 0, 0, 1);
        set_instr(7'b0110011, 3'b000, 7'h20);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_EXEC_R, 1, 0, 0, 0);
        plan(ST_ALU_WB, 1, 0, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL b2b c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            checks++;
            if (retired !== e.er) begin errors++; $display("FAIL b2b c%0d retired got %0d exp %0d", cyc, retired, e.er); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_rst_mid_write();
        ent_t e;
        int cyc = 0;
        set_instr(7'b0110011, 3'b000, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_EXEC_R, 1, 0, 0, 0);
        plan(ST_ALU_WB, 1, 0, 0, 1);
        set_instr(7'b0100011, 3'b010, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_MEM_ADDR, 1, 0, 0, 0);
        plan(ST_MEM_WRITE, 0, 0, 0, 0); plan(ST_MEM_WRITE, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL mid_write c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            checks++;
            if (retired !== e.er) begin errors++; $display("FAIL mid_write c%0d retired got %0d exp %0d", cyc, retired, e.er); end
            @(posedge clk); #1; cyc++;
        end
        test_reset("mid_write");
    endtask

    task automatic test_illegal();
        ent_t e;
        int cyc = 0;
        logic [16:0] tab [3];
        logic [16:0] t;
        // {opcode, funct3, funct7}
        tab = '{{7'h7F, 3'b000, 7'h00}, {7'b1100011, 3'b010, 7'h00}, {7'b0110011, 3'b000, 7'h01}};
        for (int i = 0; i < 3; i++) begin
            t = tab[i];
            set_instr(t[16:10], t[9:7], t[6:0]);
            plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0);
            plan(ST_TRAP, 1, 0, 2'b01, 0); plan(ST_TRAP, 1, 0, 2'b01, 0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); drive(e);
                @(negedge clk);
                checks++;
                if (obs() !== e.ev) begin errors++; $display("FAIL illegal%0d c%0d vec got %h exp %h", i, cyc, obs(), e.ev); end
                @(posedge clk); #1; cyc++;
            end
            test_reset("illegal");
        end
    endtask

    task automatic test_timeout();
        ent_t e;
        int cyc = 0;
        set_instr(7'b0000011, 3'b010, 7'h00);
        plan(ST_FETCH, 1, 0, 0, 0); plan(ST_DECODE, 1, 0, 0, 0); plan(ST_MEM_ADDR, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) plan(ST_MEM_READ, 0, 0, 0, 0);
        plan(ST_TRAP, 0, 0, 2'b10, 0); plan(ST_TRAP, 1, 0, 2'b10, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e);
            @(negedge clk);
            checks++;
            if (obs() !== e.ev) begin errors++; $display("FAIL timeout c%0d vec got %h exp %h", cyc, obs(), e.ev); end
            @(posedge clk); #1; cyc++;
        end
        test_reset("timeout");
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== exp_vec(ST_FETCH, 1, 0, 0)) begin
            errors++;
            $display("FAIL timeout_restart vec got %h exp %h", obs(), exp_vec(ST_FETCH, 1, 0, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
        bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        test_reset("por");
        test_add();
        test_reset("after_add");
        test_fetch_wait();
        test_branch();
        test_jalr();
        test_back_to_back();
        test_reset("before_mid_write");
        test_rst_mid_write();
        test_illegal();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
